icache_mem_rsp: RTL



---
 rtl/icache_mem_rsp_pkg.sv | 22 ++
 rtl/icache_mem_rsp_mem_word_ram.sv | 22 ++
 rtl/icache_mem_rsp.sv | 126 ++++++++++++
 3 files changed

// File: rtl/icache_mem_rsp_pkg.sv
// Shared constants and FSM encoding for the I-Cache refill memory responder.
package icache_mem_rsp_pkg;

    localparam int BURST_LEN  = 8;
    localparam int BEAT_W     = $clog2(BURST_LEN);
    localparam int LINE_OFF_W = 5;
    localparam int WORD_W     = 32;

    // One-hot state bit positions, so outputs can be taken straight off a state bit
    localparam int IS_IDLE  = 0;
    localparam int IS_DELAY = 1;
    localparam int IS_FETCH = 2;
    localparam int IS_SEND  = 3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_DELAY = 4'b0010,
        S_FETCH = 4'b0100,
        S_SEND  = 4'b1000
    } state_t;

endpackage

// File: rtl/icache_mem_rsp_mem_word_ram.sv
// 1R1W synchronous word RAM, read-first; the read register only updates when ren is high.
module mem_word_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              ren,
    input  logic [MEM_AW-1:0] raddr,
    output logic [31:0]       rdata
);
    import icache_mem_rsp_pkg::*;

    logic [WORD_W-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
    end

endmodule

// File: rtl/icache_mem_rsp.sv
// Line-read responder: returns eight words of a 32-byte line as a burst with last flag.
// Optional MEM_RSP_DELAY_EN inserts RSP_DELAY idle cycles between accept and first fetch.
module icache_mem_rsp #(
    parameter int MEM_AW    = 12,
    parameter int BURST_LEN = 8,
    parameter int RSP_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              from_cache_rd_req_valid,
    input  logic [31:0]       from_cache_rd_req_addr,
    output logic              to_cache_rd_req_ready,
    output logic              to_cache_rd_rsp_valid,
    output logic [31:0]       to_cache_rd_rsp_data,
    output logic              to_cache_rd_rsp_last,
    input  logic              from_cache_rd_rsp_ready,
    input  logic              init_wen,
    input  logic [MEM_AW-1:0] init_addr,
    input  logic [31:0]       init_wdata
);
    import icache_mem_rsp_pkg::*;

    state_t                     state_q, state_d;
    logic [MEM_AW-BEAT_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic                       ram_ren;
    logic [WORD_W-1:0]          ram_q;
    logic                       accept;
    logic                       unused_bits;

    assign accept = from_cache_rd_req_valid & to_cache_rd_req_ready;

`ifdef MEM_RSP_DELAY_EN
    localparam int DLY_W = (RSP_DELAY > 1) ? $clog2(RSP_DELAY + 1) : 1;
    logic [DLY_W-1:0] dly_q, dly_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dly_q <= '0;
        else      dly_q <= dly_d;
    end
    assign unused_bits = ^{from_cache_rd_req_addr[31:MEM_AW+2],
                           from_cache_rd_req_addr[LINE_OFF_W-1:0]};
`else
    assign unused_bits = ^{from_cache_rd_req_addr[31:MEM_AW+2],
                           from_cache_rd_req_addr[LINE_OFF_W-1:0], 32'(RSP_DELAY)};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        ram_ren = 1'b0;
`ifdef MEM_RSP_DELAY_EN
        dly_d   = dly_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    base_d = from_cache_rd_req_addr[MEM_AW+1:LINE_OFF_W];
                    beat_d = '0;
`ifdef MEM_RSP_DELAY_EN
                    if (RSP_DELAY == 0) begin
                        state_d = S_FETCH;
                    end else begin
                        // Loaded one short so DELAY lasts exactly RSP_DELAY cycles
                        state_d = S_DELAY;
                        dly_d   = DLY_W'(RSP_DELAY - 1);
                    end
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef MEM_RSP_DELAY_EN
            S_DELAY: begin
                if (dly_q == '0) state_d = S_FETCH;
                else             dly_d   = dly_q - DLY_W'(1);
            end
`endif
            S_FETCH: begin
                ram_ren = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (from_cache_rd_rsp_ready) begin
                    if (to_cache_rd_rsp_last) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RAM read register holds the beat while SEND waits; masking keeps data 0 elsewhere
    assign to_cache_rd_req_ready = rst & state_q[IS_IDLE];
    assign to_cache_rd_rsp_valid = state_q[IS_SEND];
    assign to_cache_rd_rsp_last  = state_q[IS_SEND] & (beat_q == BEAT_W'(BURST_LEN - 1));
    assign to_cache_rd_rsp_data  = state_q[IS_SEND] ? ram_q : '0;

    mem_word_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk   (clk),
        .wen   (init_wen),
        .waddr (init_addr),
        .wdata (init_wdata),
        .ren   (ram_ren),
        .raddr ({base_q, beat_q}),
        .rdata (ram_q)
    );

endmodule
